data_mem_module: RTL
====================

# data_mem_module

Data-memory responder for the pipelined RV32IM core: the slave end of the MEM-stage load/store interface. Accepts read/write requests from the EX/MEM pipeline register, holds the pipeline with BUSYWAIT for a fixed access latency, and performs byte, halfword and word loads and stores selected by FUNC3. Loads are sign- or zero-extended. Returned data feeds the MEM/WB register.

## Interface
- DEPTH_WORDS, 256: number of 32-bit words in the array; power of two.
- LATENCY, 4: cycles BUSYWAIT stays high per access; legal range ≥2.
- CLK  in  1  single clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- READ_EN  in  1  load request.
- WRITE_EN  in  1  store request.
- ADDR  in  32  byte address.
- WRITE_DATA  in  32  store data, right-aligned.
- FUNC3  in  3  access size and extension.
- READ_DATA  out  32  extended load result.
- BUSYWAIT  out  1  stall request to the pipeline.

## Operation
- FSM states:
  - IDLE: BUSYWAIT = READ_EN | WRITE_EN (combinational). On a request, latch ADDR, WRITE_DATA, FUNC3 and type; load the counter with LATENCY-2; go to ACCESS.
  - ACCESS: BUSYWAIT = 1. While counter ≠ 0, decrement it. When counter = 0, perform the access at this edge and go to DONE.
  - DONE: BUSYWAIT = 0 regardless of the request inputs. Unconditionally return to IDLE.
- READ_EN and WRITE_EN both high: treated as a store. READ_DATA is unchanged.
- Word index = ADDR[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so out-of-range addresses alias (wrap-around).
- Loads:
  - LB (000) / LBU (100): byte lane ADDR[1:0], sign- or zero-extended.
  - LH (001) / LHU (101): half lane ADDR[1]; ADDR[0] is ignored.
  - LW (010): ADDR[1:0] are ignored.
  - Any other FUNC3: returns 0.
- Stores:
  - SB (000), SH (001), SW (010) write only the addressed lanes, using the same lane rules as loads. Other lanes are preserved.
  - Any other FUNC3: no write.
- Every request completes the full handshake, including illegal FUNC3.
- READ_DATA holds its last load result until the next load completes. Stores do not change it.
- Requests are latched in IDLE. Input changes or request deassertion during ACCESS are ignored, so a flushed request still completes.

## Timing
- Reset (RESET low):
  - State IDLE, counter 0, READ_DATA 0.
  - BUSYWAIT forced to 0 while RESET is low.
  - Array contents are not cleared.
- Reset mid-ACCESS abandons the request; no write occurs.
- Let cycle 0 be an IDLE cycle with a request:
  - BUSYWAIT is high in cycles 0 through LATENCY-1 (exactly LATENCY cycles).
  - The access happens at the edge ending cycle LATENCY-1.
  - Cycle LATENCY is DONE: BUSYWAIT low, READ_DATA valid. The pipeline advances at the edge ending that cycle.
- Back-to-back: a new request present in cycle LATENCY+1 (IDLE) raises BUSYWAIT that same cycle. Minimum spacing between requests is LATENCY+1 cycles.
- No request in IDLE: BUSYWAIT stays 0 and there is zero stall.

## Structure
- Shared package holds:
  - FUNC3 load/store encodings (LB, LH, LW, LBU, LHU, SB, SH, SW);
  - FSM state encoding (IDLE, ACCESS, DONE);
  - counter width function of LATENCY.
- Sub-module mem_lane_align_module (combinational) provides:
  - store path: 4-bit byte-enable plus lane-shifted write data from FUNC3/ADDR[1:0];
  - load path: extraction and sign/zero extension.
- Top level holds the FSM, counter, request latches and the array.

## Test plan
All scenarios use LATENCY=4.
- Reset: hold RESET low with READ_EN=1 → BUSYWAIT=0 and READ_DATA=0. Release RESET → BUSYWAIT rises in the same cycle.
- SW 0xDEADBEEF to 0x10, then LW 0x10 → BUSYWAIT high exactly 4 cycles per access; READ_DATA=0xDEADBEEF in the DONE cycle.
- SB 0x80 to 0x13 over that word:
  - LB 0x13 → 0xFFFFFF80; LBU 0x13 → 0x00000080;
  - LW 0x10 → 0x80ADBEEF.
- SH 0x8001 to 0x12:
  - LH 0x12 → 0xFFFF8001; LHU 0x13 → 0x00008001 (ADDR[0] ignored).
- Aliasing and illegal FUNC3:
  - LW at 0x10+4·DEPTH_WORDS returns the word at 0x10.
  - FUNC3=011 store leaves memory unchanged.
  - FUNC3=011 load returns 0 after a full 4-cycle handshake.
- RESET pulsed low during cycle 2 of an SW → state IDLE, no write (subsequent LW returns the old value). A request held in DONE gets BUSYWAIT=0, then is re-accepted in IDLE.

Source files
------------

// File: rtl/data_mem_module_pkg.sv
// Shared encodings for the data-memory responder: FUNC3 load/store codes,
// FSM states and the access-counter width helper.
package data_mem_module_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Counter must hold LATENCY-2; keep at least one bit for LATENCY=2.
    function automatic int cnt_width(input int latency);
        int w;
        w = $clog2(latency - 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/data_mem_module_lane_align.sv
// Byte-lane steering for the data memory: byte enables and replicated write data
// for stores, lane extraction with sign/zero extension for loads. Purely combinational.
module mem_lane_align_module
    import data_mem_module_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wr_data_in,
    input  logic [31:0] rd_word,
    output logic [3:0]  byte_en,
    output logic [31:0] wr_data_out,
    output logic [31:0] rd_data
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        byte_en     = 4'b0000;
        wr_data_out = wr_data_in;
        case (func3)
            F3_SB: begin
                byte_en     = 4'b0001 << addr_lo;
                wr_data_out = {4{wr_data_in[7:0]}};
            end
            F3_SH: begin
                byte_en     = addr_lo[1] ? 4'b1100 : 4'b0011;
                wr_data_out = {2{wr_data_in[15:0]}};
            end
            F3_SW:   byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

    always_comb begin
        rd_byte = rd_word[7:0];
        case (addr_lo)
            2'd0: rd_byte = rd_word[7:0];
            2'd1: rd_byte = rd_word[15:8];
            2'd2: rd_byte = rd_word[23:16];
            2'd3: rd_byte = rd_word[31:24];
            default: rd_byte = rd_word[7:0];
        endcase
        rd_half = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
    end

    always_comb begin
        rd_data = 32'h0;
        case (func3)
            F3_LB:   rd_data = {{24{rd_byte[7]}}, rd_byte};
            F3_LBU:  rd_data = {24'h0, rd_byte};
            F3_LH:   rd_data = {{16{rd_half[15]}}, rd_half};
            F3_LHU:  rd_data = {16'h0, rd_half};
            F3_LW:   rd_data = rd_word;
            default: rd_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_mem_module.sv
// MEM-stage data memory: latches a request in IDLE, stalls via BUSYWAIT for LATENCY cycles,
// accesses the array on the last stalled edge and releases the pipeline in DONE.
module data_mem_module
    import data_mem_module_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ_EN,
    input  logic        WRITE_EN,
    input  logic [31:0] ADDR,
    input  logic [31:0] WRITE_DATA,
    input  logic [2:0]  FUNC3,
    output logic [31:0] READ_DATA,
    output logic        BUSYWAIT
);

    localparam int IW = $clog2(DEPTH_WORDS);
    localparam int CW = cnt_width(LATENCY);
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 2);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW+1:0]   addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [2:0]      func3_q, func3_d;
    logic            store_q, store_d;
    logic [31:0]     read_data_q, read_data_d;
    logic [31:0]     mem_q [DEPTH_WORDS];

    logic            req;
    logic            access_now;
    logic [IW-1:0]   idx;
    logic [3:0]      byte_en;
    logic [31:0]     st_data;
    logic [31:0]     ld_data;
    logic            unused_addr_hi;

    assign req            = READ_EN | WRITE_EN;
    assign access_now     = (state_q == ST_ACCESS) && (cnt_q == '0);
    assign idx            = addr_q[IW+1:2];
    assign unused_addr_hi = ^ADDR[31:IW+2];

    mem_lane_align_module u_align (
        .func3       (func3_q),
        .addr_lo     (addr_q[1:0]),
        .wr_data_in  (wdata_q),
        .rd_word     (mem_q[idx]),
        .byte_en     (byte_en),
        .wr_data_out (st_data),
        .rd_data     (ld_data)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            func3_q     <= '0;
            store_q     <= 1'b0;
            read_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            func3_q     <= func3_d;
            store_q     <= store_d;
            read_data_q <= read_data_d;
        end
    end

    // Request fields are captured only in IDLE so a flush during ACCESS cannot alter the access.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        func3_d     = func3_q;
        store_d     = store_q;
        read_data_d = read_data_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_ACCESS;
                    cnt_d   = CNT_LOAD;
                    addr_d  = ADDR[IW+1:0];
                    wdata_d = WRITE_DATA;
                    func3_d = FUNC3;
                    store_d = WRITE_EN;
                end
            end
            ST_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = ST_DONE;
                    if (!store_q) read_data_d = ld_data;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        BUSYWAIT = 1'b0;
        case (state_q)
            ST_IDLE:   BUSYWAIT = req;
            ST_ACCESS: BUSYWAIT = 1'b1;
            ST_DONE:   BUSYWAIT = 1'b0;
            default:   BUSYWAIT = 1'b0;
        endcase
        if (!RESET) BUSYWAIT = 1'b0;
    end

    assign READ_DATA = read_data_q;

    // Array is deliberately left out of reset; contents survive a pipeline reset.
    always_ff @(posedge CLK) begin
        if (RESET && access_now && store_q) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) mem_q[idx][8*b +: 8] <= st_data[8*b +: 8];
            end
        end
    end

endmodule
